dma_engine: RTL and testbench

- Single-channel memory-to-memory DMA master that drives the commutator's DMA master port (master3 side).
- Copies LEN 32-bit words from SRC to DST using 16-bit word addresses: read one word, then write it.
- Configured by the CPU through a small register slave port, which is mapped behind the IO slave path.
- The commutator gives the DMA priority on the RAM data port while the DMA's strobe is high.

---
 rtl/dma_pkg.sv | 29 ++
 rtl/dma_cfg_regs.sv | 125 ++++++++++++
 rtl/dma_engine.sv | 205 ++++++++++++++++++++
 tb/tb_dma_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel DMA engine: FSM states,
// register indices and CTRL/STATUS bit positions.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RD_GAP = 3'd2,
    ST_WR     = 3'd3,
    ST_WR_GAP = 3'd4,
    ST_DONE   = 3'd5
  } dma_state_e;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_IE    = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;
  localparam int STAT_IE      = 3;
  localparam int STAT_CNT_LSB = 16;

endpackage

// File: rtl/dma_cfg_regs.sv
// DMA configuration slave: ack generation, SRC/DST/LEN/IE storage,
// registered read-back and START/ABORT command pulses.
// The IE bit exists only when DMA_IRQ_EN is defined.
module dma_cfg_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_stb,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              cfg_ack,
  input  logic              busy,
  input  logic              done,
  input  logic              aborted,
  input  logic [LEN_W-1:0]  cnt,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
`ifdef DMA_IRQ_EN
  output logic              ie,
`endif
  output logic              start,
  output logic              abort
);

  logic              ack_r;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [LEN_W-1:0]  len_r;
  logic              ie_s;
  logic              access_s;
  logic              wr_s;
  logic              ctrl_wr_s;
  logic [DATA_W-1:0] status_s;
  logic [DATA_W-1:0] rd_mux_s;
  logic              unused_wdata;

  // An access is taken when the strobe is seen while no ack is outstanding.
  assign access_s  = cfg_stb & ~ack_r;
  assign wr_s      = access_s & cfg_we;
  assign ctrl_wr_s = wr_s & (cfg_addr == REG_CTRL);
  assign start     = ctrl_wr_s & cfg_wdata[CTRL_START];
  assign abort     = ctrl_wr_s & cfg_wdata[CTRL_ABORT];

  assign cfg_ack   = ack_r;
  assign cfg_rdata = rdata_r;
  assign src       = src_r;
  assign dst       = dst_r;
  assign len       = len_r;
  assign unused_wdata = ^cfg_wdata[DATA_W-1:LEN_W];

`ifdef DMA_IRQ_EN
  logic ie_r;
  assign ie   = ie_r;
  assign ie_s = ie_r;

  // Interrupt enable is stored on every CTRL write, busy or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      ie_r <= cfg_wdata[CTRL_IE];
    end else begin
      ie_r <= ie_r;
    end
  end
`else
  assign ie_s = 1'b0;
`endif

  // Assemble the STATUS word from engine state.
  always_comb begin
    status_s                          = '0;
    status_s[STAT_BUSY]               = busy;
    status_s[STAT_DONE]               = done;
    status_s[STAT_ABORTED]            = aborted;
    status_s[STAT_IE]                 = ie_s;
    status_s[STAT_CNT_LSB +: LEN_W]   = cnt;
  end

  // Select the read-back word for the addressed register.
  always_comb begin
    rd_mux_s = '0;
    case (cfg_addr)
      REG_SRC:  rd_mux_s[ADDR_W-1:0] = src_r;
      REG_DST:  rd_mux_s[ADDR_W-1:0] = dst_r;
      REG_LEN:  rd_mux_s[LEN_W-1:0]  = len_r;
      REG_CTRL: rd_mux_s             = status_s;
      default:  rd_mux_s             = '0;
    endcase
  end

  // Ack pulse, registered read data and parameter writes (frozen while busy).
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r   <= 1'b0;
      rdata_r <= '0;
      src_r   <= '0;
      dst_r   <= '0;
      len_r   <= '0;
    end else begin
      ack_r <= access_s;
      if (access_s) begin
        rdata_r <= rd_mux_s;
      end
      if (wr_s && !busy) begin
        case (cfg_addr)
          REG_SRC: src_r <= cfg_wdata[ADDR_W-1:0];
          REG_DST: dst_r <= cfg_wdata[ADDR_W-1:0];
          REG_LEN: len_r <= cfg_wdata[LEN_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/dma_engine.sv
// Single-channel memory-to-memory DMA master: copies LEN words from SRC
// to DST, one read then one write per word, with a mandatory idle gap
// after each bus phase. Optional completion interrupt: DMA_IRQ_EN.
module dma_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_stb_i,
  input  logic              cfg_we_i,
  input  logic [1:0]        cfg_addr_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  output logic [DATA_W-1:0] cfg_data_o,
  output logic              cfg_ack_o,
  output logic              m_wb_stb_o,
  output logic              m_wb_we_o,
  output logic [ADDR_W-1:0] m_wb_addr_o,
  output logic [DATA_W-1:0] m_wb_data_o,
  input  logic              m_wb_ack_i,
`ifdef DMA_IRQ_EN
  output logic              irq_o,
`endif
  input  logic [DATA_W-1:0] m_wb_data_i
);

  dma_state_e        state_r;
  logic [ADDR_W-1:0] src_w_r;
  logic [ADDR_W-1:0] dst_w_r;
  logic [LEN_W-1:0]  cnt_r;
  logic [DATA_W-1:0] buf_r;
  logic              stb_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic              done_r;
  logic              aborted_r;
  logic              abort_pend_r;

  logic [ADDR_W-1:0] src_s;
  logic [ADDR_W-1:0] dst_s;
  logic [LEN_W-1:0]  len_s;
  logic              start_s;
  logic              abort_s;
  logic              busy_s;
  logic              abort_any_s;
  logic              bus_ack_s;

  assign busy_s      = (state_r != ST_IDLE) && (state_r != ST_DONE);
  assign abort_any_s = abort_s | abort_pend_r;
  assign bus_ack_s   = stb_r & m_wb_ack_i;

  assign m_wb_stb_o  = stb_r;
  assign m_wb_we_o   = we_r;
  assign m_wb_addr_o = addr_r;
  assign m_wb_data_o = buf_r;

`ifdef DMA_IRQ_EN
  logic ie_s;
  logic irq_r;
  assign irq_o = irq_r;

  // Level interrupt that follows the sticky DONE flag gated by IE.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= done_r & ie_s;
    end
  end
`endif

  dma_cfg_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_cfg (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .cfg_stb   (cfg_stb_i),
    .cfg_we    (cfg_we_i),
    .cfg_addr  (cfg_addr_i),
    .cfg_wdata (cfg_data_i),
    .cfg_rdata (cfg_data_o),
    .cfg_ack   (cfg_ack_o),
    .busy      (busy_s),
    .done      (done_r),
    .aborted   (aborted_r),
    .cnt       (cnt_r),
    .src       (src_s),
    .dst       (dst_s),
    .len       (len_s),
`ifdef DMA_IRQ_EN
    .ie        (ie_s),
`endif
    .start     (start_s),
    .abort     (abort_s)
  );

  // Transfer FSM; an abort during a bus phase waits for that phase's ack.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      src_w_r      <= '0;
      dst_w_r      <= '0;
      cnt_r        <= '0;
      buf_r        <= '0;
      stb_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      abort_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            src_w_r      <= src_s;
            dst_w_r      <= dst_s;
            cnt_r        <= len_s;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            abort_pend_r <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= src_s;
            if (len_s == '0) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_RD;
              stb_r   <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (bus_ack_s) begin
            buf_r <= m_wb_data_i;
            stb_r <= 1'b0;
            if (abort_any_s) begin
              state_r      <= ST_IDLE;
              aborted_r    <= 1'b1;
              abort_pend_r <= 1'b0;
            end else begin
              state_r <= ST_RD_GAP;
            end
          end else if (abort_s) begin
            abort_pend_r <= 1'b1;
          end
        end
        ST_RD_GAP: begin
          if (abort_s) begin
            state_r   <= ST_IDLE;
            aborted_r <= 1'b1;
          end else begin
            state_r <= ST_WR;
            stb_r   <= 1'b1;
            we_r    <= 1'b1;
            addr_r  <= dst_w_r;
          end
        end
        ST_WR: begin
          if (bus_ack_s) begin
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            src_w_r <= src_w_r + ADDR_W'(1);
            dst_w_r <= dst_w_r + ADDR_W'(1);
            cnt_r   <= cnt_r - LEN_W'(1);
            if (abort_any_s) begin
              state_r      <= ST_IDLE;
              aborted_r    <= 1'b1;
              abort_pend_r <= 1'b0;
            end else begin
              state_r <= ST_WR_GAP;
            end
          end else if (abort_s) begin
            abort_pend_r <= 1'b1;
          end
        end
        ST_WR_GAP: begin
          if (abort_s) begin
            state_r   <= ST_IDLE;
            aborted_r <= 1'b1;
          end else if (cnt_r == '0) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RD;
            stb_r   <= 1'b1;
            addr_r  <= src_w_r;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          stb_r   <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine with a simple bus slave
// whose ack latency is programmable.
module tb_dma_engine;

  logic        clk;
  logic        rst;
  logic        cfg_stb;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_ack;
  logic        stb;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  int          ack_dly;
  int          wcnt;
  int          cyc;
  int          stb_cycles;
  int          n_tx;
  logic [15:0] rd_base;
  logic        log_we   [32];
  logic [15:0] log_addr [32];
  logic [31:0] log_data [32];
  int          log_cyc  [32];

  dma_engine dut (
    .sys_clk     (clk),
    .sys_rst     (rst),
    .cfg_stb_i   (cfg_stb),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_wdata),
    .cfg_data_o  (cfg_rdata),
    .cfg_ack_o   (cfg_ack),
    .m_wb_stb_o  (stb),
    .m_wb_we_o   (we),
    .m_wb_addr_o (addr),
    .m_wb_data_o (wdata),
    .m_wb_ack_i  (ack),
`ifdef DMA_IRQ_EN
    .irq_o       (irq),
`endif
    .m_wb_data_i (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus slave: acks ack_dly+1 cycles after stb rises, logs each completed phase.
  initial begin
    ack = 1'b0; rdata = 32'h0; wcnt = 0; cyc = 0; stb_cycles = 0; n_tx = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stb) stb_cycles++;
      if (rst) begin
        ack = 1'b0; wcnt = 0;
      end else if (ack) begin
        ack = 1'b0;
      end else if (stb) begin
        if (wcnt == ack_dly) begin
          ack = 1'b1; wcnt = 0;
          if (!we) rdata = 32'hA0 + 32'(16'(addr - rd_base));
          if (n_tx < 32) begin
            log_we[n_tx]   = we;
            log_addr[n_tx] = addr;
            log_data[n_tx] = we ? wdata : rdata;
            log_cyc[n_tx]  = cyc;
          end
          n_tx++;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] q);
    logic got;
    got = 1'b0;
    q   = 32'hx;
    @(posedge clk); #1;
    cfg_stb = 1'b1; cfg_we = w; cfg_addr = a; cfg_wdata = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (cfg_ack) begin
        got = 1'b1;
        q   = cfg_rdata;
      end
    end
    cfg_stb = 1'b0; cfg_we = 1'b0;
    if (!got) begin
      errors++;
      $display("FAIL cfg_ack timeout: observed 0 expected 1");
    end
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    cfg_xfer(1'b1, a, d, q);
  endtask

  task automatic cfg_rd(input logic [1:0] a, output logic [31:0] q);
    cfg_xfer(1'b0, a, 32'h0, q);
  endtask

  task automatic wait_idle();
    logic [31:0] q;
    q = 32'h1;
    for (int i = 0; i < 200 && q[0]; i++) cfg_rd(2'd3, q);
    if (q[0]) begin
      errors++;
      $display("FAIL wait_idle timeout: observed busy expected idle");
    end
  endtask

  task automatic wait_bus(input logic want_we);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (stb && (we == want_we)) seen = 1'b1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL wait_bus timeout: observed no phase expected we=%0d", want_we);
    end
  endtask

  logic [31:0] q;

  initial begin
    rst = 1'b1; cfg_stb = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'h0;
    ack_dly = 1; rd_base = 16'h8000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", {31'h0, stb}, 32'h0);
    check("rst_we", {31'h0, we}, 32'h0);
    check("rst_addr", {16'h0, addr}, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_cfg_ack", {31'h0, cfg_ack}, 32'h0);
    check("rst_cfg_data", cfg_rdata, 32'h0);
`ifdef DMA_IRQ_EN
    check("rst_irq", {31'h0, irq}, 32'h0);
`endif
    rst = 1'b0;
    cfg_rd(2'd3, q); check("rst_status", q, 32'h0);
    cfg_rd(2'd0, q); check("rst_src", q, 32'h0);

    // 1: four-word copy with single-cycle-latency slave
    cfg_wr(2'd0, 32'h8000); cfg_wr(2'd1, 32'h8100); cfg_wr(2'd2, 32'd4);
    cfg_rd(2'd0, q); check("src_rb", q, 32'h8000);
    n_tx = 0; rd_base = 16'h8000;
    cfg_wr(2'd3, 32'h1);
    wait_idle();
    check("t1_ntx", 32'(n_tx), 32'd8);
    for (int k = 0; k < 4; k++) begin
      check("t1_rd_we", {31'h0, log_we[2*k]}, 32'h0);
      check("t1_rd_addr", {16'h0, log_addr[2*k]}, 32'h8000 + 32'(k));
      check("t1_wr_we", {31'h0, log_we[2*k+1]}, 32'h1);
      check("t1_wr_addr", {16'h0, log_addr[2*k+1]}, 32'h8100 + 32'(k));
      check("t1_wr_data", log_data[2*k+1], 32'hA0 + 32'(k));
      if (k > 0) check("t1_word_cycles", 32'(log_cyc[2*k] - log_cyc[2*k-2]), 32'd6);
    end
    cfg_rd(2'd3, q); check("t1_status", q, 32'h0000_0002);

    // 2: zero-length transfer never touches the bus
    cfg_wr(2'd2, 32'd0);
    stb_cycles = 0;
    cfg_wr(2'd3, 32'h1);
    cfg_rd(2'd3, q); check("t2_status", q, 32'h0000_0002);
    check("t2_no_stb", 32'(stb_cycles), 32'd0);

    // 3: source address wraps from FFFF to 0000
    cfg_wr(2'd0, 32'hFFFF); cfg_wr(2'd1, 32'h8000); cfg_wr(2'd2, 32'd2);
    n_tx = 0; rd_base = 16'hFFFF;
    cfg_wr(2'd3, 32'h1);
    wait_idle();
    check("t3_ntx", 32'(n_tx), 32'd4);
    check("t3_rd0", {16'h0, log_addr[0]}, 32'hFFFF);
    check("t3_rd1", {16'h0, log_addr[2]}, 32'h0000);
    check("t3_wr1_addr", {16'h0, log_addr[3]}, 32'h8001);
    check("t3_wr1_data", log_data[3], 32'hA1);
    cfg_rd(2'd3, q); check("t3_status", q, 32'h0000_0002);

    // 4: abort during a slow write phase; the write is allowed to finish
    cfg_wr(2'd0, 32'h8000); cfg_wr(2'd1, 32'h8100); cfg_wr(2'd2, 32'd8);
    n_tx = 0; rd_base = 16'h8000; ack_dly = 5;
    cfg_wr(2'd3, 32'h1);
    wait_bus(1'b1);
    cfg_wr(2'd3, 32'h2);
    check("t4_stb_held", {31'h0, stb}, 32'h1);
    check("t4_we_held", {31'h0, we}, 32'h1);
    wait_idle();
    check("t4_ntx", 32'(n_tx), 32'd2);
    check("t4_stb_low", {31'h0, stb}, 32'h0);
    cfg_rd(2'd3, q); check("t4_status", q, 32'h0007_0004);

    // 5: parameter writes while busy are ignored
    ack_dly = 1;
    cfg_wr(2'd0, 32'h8200); cfg_wr(2'd1, 32'h8300); cfg_wr(2'd2, 32'd2);
    n_tx = 0; rd_base = 16'h8200;
    cfg_wr(2'd3, 32'h1);
    cfg_wr(2'd0, 32'h1111); cfg_wr(2'd1, 32'h2222); cfg_wr(2'd2, 32'd9);
    wait_idle();
    check("t5_ntx", 32'(n_tx), 32'd4);
    check("t5_rd1", {16'h0, log_addr[2]}, 32'h8201);
    check("t5_wr1", {16'h0, log_addr[3]}, 32'h8301);
    cfg_rd(2'd0, q); check("t5_src_kept", q, 32'h8200);
    cfg_rd(2'd2, q); check("t5_len_kept", q, 32'd2);

    // 5b: reset in the middle of a read phase
    ack_dly = 10;
    cfg_wr(2'd3, 32'h1);
    wait_bus(1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_stb", {31'h0, stb}, 32'h0);
    check("t5_rst_addr", {16'h0, addr}, 32'h0);
    check("t5_rst_wdata", wdata, 32'h0);
    rst = 1'b0; ack_dly = 1;
    cfg_rd(2'd3, q); check("t5_rst_status", q, 32'h0);
    cfg_rd(2'd0, q); check("t5_rst_src", q, 32'h0);

    // 6: START together with ABORT in IDLE -> START wins; IE visibility
    cfg_wr(2'd2, 32'd1);
    rd_base = 16'h0;
    cfg_wr(2'd3, 32'h7);
    wait_idle();
`ifdef DMA_IRQ_EN
    cfg_rd(2'd3, q); check("t6_status", q, 32'h0000_000A);
    check("t6_irq_set", {31'h0, irq}, 32'h1);
    cfg_wr(2'd3, 32'h5);
    @(posedge clk); #1;
    check("t6_irq_clr", {31'h0, irq}, 32'h0);
    wait_idle();
`else
    cfg_rd(2'd3, q); check("t6_status", q, 32'h0000_0002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
